div_iter: RTL and testbench

Parametrised iterative restoring divider for the EX stage of the pipelined MIPS core. It is the successor to the fixed 32-bit divider behind the current div_ready/div_stall path. It is generalised in operand width and adds signed/unsigned mode, explicit cancel (exception flush), divide-by-zero handling and a busy/ready handshake. Result is packed {remainder, quotient} so it drops straight onto the HI/LO write path.

---
 rtl/div_iter.sv | 177 +++++++++++++++++
 tb/tb_div_iter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider with signed/unsigned mode, cancel,
// divide-by-zero handling and a busy/ready handshake.
// Result is packed {remainder, quotient}.
// Optional feature macro: DIV_EARLY_OUT_EN. When defined, divisions with
// |opa| < |opb| or |opb| == 1 finish straight from IDLE. The result values
// are the same as on the full path; only the latency changes.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               cancel_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_ZERO, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;    // partial remainder (always < divisor)
  logic [WIDTH-1:0]     quo_q, quo_d;    // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]     div_q, div_d;    // divisor magnitude
  logic                 nega_q, nega_d;  // dividend negative (signed mode only)
  logic                 negb_q, negb_d;  // divisor negative (signed mode only)
  logic [2*WIDTH-1:0]   fin_q, fin_d;    // sign-corrected result presented in DONE
  logic [2*WIDTH-1:0]   res_q, res_d;    // last delivered result, held between operations

  // Two's complement negate when neg is set
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ((~v) + ONE) : v;
  endfunction

  // Quotient is negative when operand signs differ
  function automatic logic [WIDTH-1:0] fix_quo(input logic [WIDTH-1:0] q,
                                               input logic na, input logic nb);
    return cond_neg(q, na ^ nb);
  endfunction

  // Remainder carries the dividend's sign
  function automatic logic [WIDTH-1:0] fix_rem(input logic [WIDTH-1:0] r, input logic na);
    return cond_neg(r, na);
  endfunction

  logic             nega_in, negb_in;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  logic [WIDTH:0]   shift_rem, trial;
  logic             step_ok;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign nega_in  = signed_i & opa_i[WIDTH-1];
  assign negb_in  = signed_i & opb_i[WIDTH-1];
  assign mag_a_in = cond_neg(opa_i, nega_in);
  assign mag_b_in = cond_neg(opb_i, negb_in);

  // One restoring step: WIDTH+1-bit shifted remainder, trial subtract, keep or restore
  assign shift_rem = {rem_q, quo_q[WIDTH-1]};
  assign trial     = shift_rem - {1'b0, div_q};
  assign step_ok   = ~trial[WIDTH];
  assign step_rem  = step_ok ? trial[WIDTH-1:0] : shift_rem[WIDTH-1:0];
  assign step_quo  = {quo_q[WIDTH-2:0], step_ok};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      nega_q <= 1'b0;
      negb_q <= 1'b0;
      fin_q  <= '0;
      res_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      nega_q <= nega_d;
      negb_q <= negb_d;
      fin_q  <= fin_d;
      res_q  <= res_d;
    end
  end

  // Next-state, datapath next values and outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    nega_d   = nega_q;
    negb_d   = negb_q;
    fin_d    = fin_q;
    res_d    = res_q;
    busy_o   = (state_q != S_IDLE);
    ready_o  = 1'b0;
    result_o = res_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !cancel_i) begin
          nega_d = nega_in;
          negb_d = negb_in;
          quo_d  = mag_a_in;
          div_d  = mag_b_in;
          rem_d  = '0;
          cnt_d  = '0;
          if (opb_i == '0) begin
            state_d = S_ZERO;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (mag_a_in < mag_b_in) begin
            fin_d   = {fix_rem(mag_a_in, nega_in), {WIDTH{1'b0}}};
            state_d = S_DONE;
          end else if (mag_b_in == ONE) begin
            fin_d   = {{WIDTH{1'b0}}, fix_quo(mag_a_in, nega_in, negb_in)};
            state_d = S_DONE;
          end
`endif
          else begin
            state_d = S_RUN;
          end
        end
      end
      S_ZERO: begin
        if (cancel_i) begin
          state_d = S_IDLE;
        end else begin
          // Sign restore of the latched magnitude gives back the raw dividend
          fin_d   = {fix_rem(quo_q, nega_q), {WIDTH{1'b1}}};
          state_d = S_DONE;
        end
      end
      S_RUN: begin
        if (cancel_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            fin_d   = {fix_rem(step_rem, nega_q), fix_quo(step_quo, nega_q, negb_q)};
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        // A cancel in DONE suppresses the pulse and keeps the old result visible
        if (!cancel_i) begin
          ready_o  = 1'b1;
          result_o = fin_q;
          res_d    = fin_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: table-driven and scoreboard-checked bench for div_iter (WIDTH=32).
module tb_div_iter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start_i = 1'b0;
  logic           cancel_i = 1'b0;
  logic           signed_i = 1'b0;
  logic [W-1:0]   opa_i = '0;
  logic [W-1:0]   opb_i = '0;
  logic           busy_o;
  logic           ready_o;
  logic [2*W-1:0] result_o;

  div_iter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .cancel_i (cancel_i),
    .signed_i (signed_i),
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .busy_o   (busy_o),
    .ready_o  (ready_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          nm;
    logic [2*W-1:0] res;
    int             lat;
  } exp_t;

  typedef struct {
    string          nm;
    logic           sg;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
  } vec_t;

  exp_t           sb_q[$];
  vec_t           vt[16];
  int             n_cmp = 0;
  int             n_bad = 0;
  int             dbl = 0;
  logic           prev_rdy = 1'b0;
  logic [2*W-1:0] last_res = '0;

  // Track back-to-back ready pulses
  always @(negedge clk) begin
    if (ready_o && prev_rdy) dbl <= dbl + 1;
    prev_rdy <= ready_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic int exp_lat(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return 2;
`ifdef DIV_EARLY_OUT_EN
    begin
      logic [W-1:0] ma, mb;
      ma = (sg && a[W-1]) ? -a : a;
      mb = (sg && b[W-1]) ? -b : b;
      if (ma < mb || mb == 1) return 1;
    end
`endif
    return W + 1;
  endfunction

  function automatic logic [2*W-1:0] model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    longint x, y, q, r;
    if (b == '0) return {a, {W{1'b1}}};
    if (sg) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // Drive one operation, push its expectation, pop and compare on ready_o.
  // glitch > 0 pulses start_i with other operands in that cycle of the run.
  task automatic do_op(input string nm, input logic sg, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2*W-1:0] res, input int glitch);
    exp_t           e;
    int             lat;
    int             bc;
    bit             got;
    logic [2*W-1:0] r;
    e.nm = nm; e.res = res; e.lat = exp_lat(sg, a, b);
    sb_q.push_back(e);
    signed_i = sg; opa_i = a; opb_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; opa_i = $urandom; opb_i = $urandom;
    lat = 0; bc = 0; got = 0; r = '0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy_o) bc++;
      if (ready_o) begin
        got = 1;
        r = result_o;
      end
      if (!got && lat == glitch) begin
        start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd5; opb_i = 32'd1;
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    e = sb_q.pop_front();
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: no ready_o within %0d cycles, required latency %0d", e.nm, lat, e.lat);
    end else begin
      chk({e.nm, " result"}, r, e.res);
      chk({e.nm, " latency"}, 64'(lat), 64'(e.lat));
      chk({e.nm, " busy cycles"}, 64'(bc), 64'(e.lat));
      last_res = e.res;
    end
    @(posedge clk); #1;
    chk({e.nm, " idle after"}, 64'(busy_o), 64'(0));
  endtask

  task automatic watch_no_ready(input string nm, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ready_o) cnt++;
    end
    chk(nm, 64'(cnt), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    vt[0]  = '{"u100/7",      1'b0, 32'd100,       32'd7,         {32'd2,         32'd14}};
    vt[1]  = '{"s-7/2",       1'b1, 32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF,  32'hFFFFFFFD}};
    vt[2]  = '{"s7/-2",       1'b1, 32'd7,         32'hFFFFFFFE,  {32'd1,         32'hFFFFFFFD}};
    vt[3]  = '{"u_div0",      1'b0, 32'h12345678,  32'd0,         {32'h12345678,  32'hFFFFFFFF}};
    vt[4]  = '{"s_min/-1",    1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'd0,         32'h80000000}};
    vt[5]  = '{"u3/10",       1'b0, 32'd3,         32'd10,        {32'd3,         32'd0}};
    vt[6]  = '{"u_max/1",     1'b0, 32'hFFFFFFFF,  32'd1,         {32'd0,         32'hFFFFFFFF}};
    vt[7]  = '{"u_max/max",   1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  {32'd0,         32'd1}};
    vt[8]  = '{"s-7/-2",      1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  {32'hFFFFFFFF,  32'd3}};
    vt[9]  = '{"u_big/2",     1'b0, 32'hFFFFFFF9,  32'd2,         {32'd1,         32'h7FFFFFFC}};
    vt[10] = '{"s-5/0",       1'b1, 32'hFFFFFFFB,  32'd0,         {32'hFFFFFFFB,  32'hFFFFFFFF}};
    vt[11] = '{"s-6/1",       1'b1, 32'hFFFFFFFA,  32'd1,         {32'd0,         32'hFFFFFFFA}};
    vt[12] = '{"s_min/1",     1'b1, 32'h80000000,  32'd1,         {32'd0,         32'h80000000}};
    vt[13] = '{"u0/5",        1'b0, 32'd0,         32'd5,         {32'd0,         32'd0}};
    vt[14] = '{"u1e6/1000",   1'b0, 32'h000F4240,  32'h000003E8,  {32'd0,         32'h000003E8}};
    vt[15] = '{"s100/-7",     1'b1, 32'd100,       32'hFFFFFFF9,  {32'd2,         32'hFFFFFFF2}};

    // Reset state while rst is held low
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy",   64'(busy_o),  64'(0));
    chk("reset ready",  64'(ready_o), 64'(0));
    chk("reset result", result_o,     '0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++)
      do_op(vt[i].nm, vt[i].sg, vt[i].a, vt[i].b, vt[i].res, 0);

    for (int i = 0; i < 16; i++) begin
      logic         sg;
      logic [W-1:0] a, b;
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 1) b = $urandom_range(1, 9);
      if (i % 4 == 2) b = -($urandom_range(1, 9));
      if (i % 4 == 3) a = $urandom_range(0, 50);
      do_op("rand", sg, a, b, model(sg, a, b), 0);
    end

    // Cancel in RUN: cancel sampled at t+10, busy low at t+11, no pulse, result held
    signed_i = 1'b0; opa_i = 32'd100; opb_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("run busy before cancel", 64'(busy_o), 64'(1));
    cancel_i = 1'b1;
    @(posedge clk); #1;
    cancel_i = 1'b0;
    chk("run cancel busy", 64'(busy_o), 64'(0));
    chk("run cancel result held", result_o, last_res);
    watch_no_ready("run cancel ready pulses", 40);
    do_op("after cancel u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);

    // start and cancel together in IDLE: nothing accepted
    signed_i = 1'b0; opa_i = 32'd9; opb_i = 32'd2; start_i = 1'b1; cancel_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; cancel_i = 1'b0;
    chk("start+cancel busy", 64'(busy_o), 64'(0));
    watch_no_ready("start+cancel ready pulses", 5);

    // start pulsed mid-run is ignored
    do_op("glitch s_min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 10);
    watch_no_ready("glitch no extra ready", 40);

    // Cancel in DONE: pulse suppressed in the same cycle, result held
    signed_i = 1'b0; opa_i = 32'h12345678; opb_i = 32'd0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    chk("done busy", 64'(busy_o), 64'(1));
    cancel_i = 1'b1;
    #1;
    chk("done cancel ready", 64'(ready_o), 64'(0));
    chk("done cancel result", result_o, last_res);
    @(posedge clk); #1;
    cancel_i = 1'b0;
    chk("done cancel busy after", 64'(busy_o), 64'(0));
    chk("done cancel result after", result_o, last_res);
    watch_no_ready("done cancel ready pulses", 5);

    // Asynchronous reset mid-RUN clears everything at once
    signed_i = 1'b0; opa_i = 32'd100; opb_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async reset busy",   64'(busy_o),  64'(0));
    chk("async reset ready",  64'(ready_o), 64'(0));
    chk("async reset result", result_o,     '0);
    last_res = '0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    watch_no_ready("async reset ready pulses", 40);
    do_op("after reset s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);

    @(negedge clk);
    chk("ready consecutive", 64'(dbl), 64'(0));
    chk("scoreboard empty", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
